// File: rtl/transaction_scheduler.sv
// Round-robin admission of wallet requests into a small FIFO, one-at-a-time issue to the
// transaction controller, and a per-transaction watchdog that aborts and reports on expiry.
module transaction_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int AMT_W   = 8,
    parameter  int DEPTH   = 4,
    parameter  int TIMEOUT = 1024,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*AMT_W-1:0] req_amount,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     start_transaction,
    output logic [ID_W-1:0]          txn_owner,
    output logic [AMT_W-1:0]         txn_amount,
    input  logic                     finished_transaction,
    output logic                     ctrl_abort,
    output logic                     done_valid,
    output logic                     done_timeout,
    output logic [ID_W-1:0]          done_owner,
    output logic                     busy,
    output logic [CNT_W-1:0]         queue_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rst_done;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [TMR_W-1:0]   r_timer;
    logic [ID_W-1:0]    r_txn_owner;
    logic [AMT_W-1:0]   r_txn_amount;
    logic [ID_W-1:0]    r_fifo_owner  [DEPTH];
    logic [AMT_W-1:0]   r_fifo_amount [DEPTH];

    logic               w_grant_en;
    logic               w_grant_valid;
    logic [ID_W-1:0]    w_grant_idx;
    logic [AMT_W-1:0]   w_grant_amount;
    logic [NUM_REQ-1:0] w_ack;
    logic               w_push;
    logic               w_pop;

    // Grants are suppressed in reset and in the first cycle after it; occupancy is the start-of-cycle value.
    assign w_grant_en = resetn && r_rst_done && (r_count < CNT_W'(DEPTH));

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_ack          = '0;
        w_grant_valid  = 1'b0;
        w_grant_idx    = '0;
        w_grant_amount = '0;
        if (w_grant_en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!w_grant_valid && req[i] && (i == (int'(r_rr_ptr) + k) % NUM_REQ)) begin
                        w_grant_valid  = 1'b1;
                        w_grant_idx    = ID_W'(i);
                        w_grant_amount = req_amount[i*AMT_W +: AMT_W];
                        w_ack[i]       = 1'b1;
                    end
                end
            end
        end
    end

    assign w_push = w_grant_valid;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RUN;
            S_RUN: begin
                if (finished_transaction)               w_state_nxt = S_DONE;
                else if (r_timer == TMR_W'(TIMEOUT - 1)) w_state_nxt = S_ABORT;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_rst_done   <= 1'b0;
            r_rr_ptr     <= ID_W'(NUM_REQ - 1);
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_txn_owner  <= '0;
            r_txn_amount <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
            if (w_push) begin
                r_rr_ptr <= w_grant_idx;
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + ADDR_W'(1);
                r_txn_owner  <= r_fifo_owner[r_rd_ptr];
                r_txn_amount <= r_fifo_amount[r_rd_ptr];
                r_timer      <= '0;
            end else if (r_state == S_RUN && r_timer != '1) begin
                r_timer <= r_timer + TMR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; entries are only read after being written, guarded by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_owner[r_wr_ptr]  <= w_grant_idx;
            r_fifo_amount[r_wr_ptr] <= w_grant_amount;
        end
    end

    assign req_ack           = w_ack;
    assign start_transaction = (r_state == S_ISSUE);
    assign txn_owner         = r_txn_owner;
    assign txn_amount        = r_txn_amount;
    assign ctrl_abort        = (r_state == S_ABORT);
    assign done_valid        = (r_state == S_DONE) || (r_state == S_ABORT);
    assign done_timeout      = (r_state == S_ABORT);
    assign done_owner        = r_txn_owner;
    assign busy              = (r_state != S_IDLE);
    assign queue_count       = r_count;

endmodule

// File: tb/tb_transaction_scheduler.sv
// Directed bench for transaction_scheduler (TIMEOUT=16): reset, issue latency, round-robin,
// full-queue back-pressure, watchdog abort, finish-vs-timeout priority and mid-run reset.
module tb_transaction_scheduler;

    localparam int NUM_REQ = 4;
    localparam int AMT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic                     clock;
    logic                     resetn;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*AMT_W-1:0] req_amount;
    logic [NUM_REQ-1:0]       req_ack;
    logic                     start_transaction;
    logic [1:0]               txn_owner;
    logic [AMT_W-1:0]         txn_amount;
    logic                     finished_transaction;
    logic                     ctrl_abort;
    logic                     done_valid;
    logic                     done_timeout;
    logic [1:0]               done_owner;
    logic                     busy;
    logic [2:0]               queue_count;

    int n_checks = 0;
    int n_fail   = 0;

    transaction_scheduler #(
        .NUM_REQ(NUM_REQ),
        .AMT_W  (AMT_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock               (clock),
        .resetn              (resetn),
        .req                 (req),
        .req_amount          (req_amount),
        .req_ack             (req_ack),
        .start_transaction   (start_transaction),
        .txn_owner           (txn_owner),
        .txn_amount          (txn_amount),
        .finished_transaction(finished_transaction),
        .ctrl_abort          (ctrl_abort),
        .done_valid          (done_valid),
        .done_timeout        (done_timeout),
        .done_owner          (done_owner),
        .busy                (busy),
        .queue_count         (queue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Two reset edges, then the dead cycle; returns in the first cycle that may grant.
    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) cyc();
        resetn = 1'b1;
        cyc();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},   32'(req_ack), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_count"}, 32'(queue_count), 0);
        check({tag, "_start"}, 32'(start_transaction), 0);
        check({tag, "_done"},  32'(done_valid), 0);
        check({tag, "_abort"}, 32'(ctrl_abort), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        resetn               = 1'b0;
        req                  = 4'b1111;
        req_amount           = 32'hAAAA_AAAA;
        finished_transaction = 1'b0;

        // Reset: outputs zero during reset and in the first cycle after, even with req high.
        repeat (3) cyc();
        check_idle_outputs("rst");
        check("rst_owner",  32'(txn_owner), 0);
        check("rst_amount", 32'(txn_amount), 0);
        resetn = 1'b1;
        #1;
        check("rst_dead_ack", 32'(req_ack), 0);
        check("rst_dead_start", 32'(start_transaction), 0);
        cyc();
        req = '0;

        // T1: ack in N, start in N+2, finish 5 cycles later.
        req        = 4'b0001;
        req_amount = '0;
        req_amount[0 +: 8] = 8'h2A;
        #1;
        check("t1_ack", 32'(req_ack), 1);
        cyc();
        req = '0;
        check("t1_n1_start", 32'(start_transaction), 0);
        check("t1_n1_count", 32'(queue_count), 1);
        cyc();
        check("t1_start",  32'(start_transaction), 1);
        check("t1_owner",  32'(txn_owner), 0);
        check("t1_amount", 32'(txn_amount), 32'h2A);
        repeat (5) cyc();
        finished_transaction = 1'b1;
        check("t1_pre_done", 32'(done_valid), 0);
        cyc();
        finished_transaction = 1'b0;
        check("t1_done",       32'(done_valid), 1);
        check("t1_done_to",    32'(done_timeout), 0);
        check("t1_done_owner", 32'(done_owner), 0);
        check("t1_done_abort", 32'(ctrl_abort), 0);
        cyc();
        check("t1_after_done", 32'(done_valid), 0);
        check("t1_after_busy", 32'(busy), 0);

        // T2: round-robin from a fresh pointer; cycle A is the first loop iteration.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) req_amount[i*8 +: 8] = 8'(8'h10 + i);
        for (int k = 0; k < 4; k++) begin
            req = 4'(4'hF << k);
            #1;
            check($sformatf("t2_ack%0d", k), 32'(req_ack), 32'(1) << k);
            if (k == 2) begin
                check("t2_start",  32'(start_transaction), 1);
                check("t2_owner",  32'(txn_owner), 0);
                check("t2_amount", 32'(txn_amount), 32'h10);
            end
            cyc();
        end
        req = 4'b1001;
        req_amount[0 +: 8] = 8'h50;
        #1;
        check("t2_rr_wrap", 32'(req_ack), 1);
        cyc();

        // T3/T4: queue full at A+5; held req only acked at A+21 after the pop at A+20.
        req = 4'b0100;
        req_amount[16 +: 8] = 8'h62;
        for (int c = 5; c <= 21; c++) begin
            #1;
            if (c == 5) check("t3_full", 32'(queue_count), 4);
            check($sformatf("t3_ack_c%0d", c),   32'(req_ack),    (c == 21) ? 4 : 0);
            check($sformatf("t4_done_c%0d", c),  32'(done_valid), (c == 19) ? 1 : 0);
            check($sformatf("t4_abort_c%0d", c), 32'(ctrl_abort), (c == 19) ? 1 : 0);
            if (c == 19) begin
                check("t4_timeout", 32'(done_timeout), 1);
                check("t4_owner",   32'(done_owner), 0);
            end
            if (c == 21) begin
                check("t4_next_start",  32'(start_transaction), 1);
                check("t4_next_owner",  32'(txn_owner), 1);
                check("t4_next_amount", 32'(txn_amount), 32'h11);
            end
            cyc();
        end
        req = '0;

        // T5: finished at the cycle where timer == TIMEOUT-1 (A+37) must win.
        check("t5_count", 32'(queue_count), 4);
        for (int c = 22; c <= 36; c++) begin
            check($sformatf("t5_run_c%0d", c), 32'(done_valid), 0);
            cyc();
        end
        finished_transaction = 1'b1;
        check("t5_no_early_abort", 32'(ctrl_abort), 0);
        cyc();
        finished_transaction = 1'b0;
        check("t5_done",    32'(done_valid), 1);
        check("t5_timeout", 32'(done_timeout), 0);
        check("t5_abort",   32'(ctrl_abort), 0);
        check("t5_owner",   32'(done_owner), 1);
        cyc();
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (start_transaction) found = 1'b1;
            else cyc();
        end
        check("t5_next_issue", 32'(found), 1);
        check("t5_next_owner", 32'(txn_owner), 2);
        check("t5_next_amount", 32'(txn_amount), 32'h12);
        cyc();

        // T6: reset mid-RUN with three entries queued.
        check("t6_pre_count", 32'(queue_count), 3);
        check("t6_pre_busy",  32'(busy), 1);
        resetn = 1'b0;
        cyc();
        check_idle_outputs("t6_rst");
        cyc();
        resetn = 1'b1;
        #1;
        check_idle_outputs("t6_dead");
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("t6_quiet_done%0d", i),  32'(done_valid), 0);
            check($sformatf("t6_quiet_start%0d", i), 32'(start_transaction), 0);
        end
        check("t6_quiet_busy", 32'(busy), 0);
        req = 4'b0100;
        req_amount[16 +: 8] = 8'h77;
        #1;
        check("t6_new_ack", 32'(req_ack), 4);
        cyc();
        req = '0;
        cyc();
        check("t6_new_start",  32'(start_transaction), 1);
        check("t6_new_owner",  32'(txn_owner), 2);
        check("t6_new_amount", 32'(txn_amount), 32'h77);
        cyc();
        finished_transaction = 1'b1;
        cyc();
        finished_transaction = 1'b0;
        check("t6_new_done",  32'(done_valid), 1);
        check("t6_new_downer", 32'(done_owner), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
